// File: rtl/gmii_rx_frame_if.sv
// GMII receive pins plus the write side of the 9-bit frame FIFO, bundled as one port.
interface gmii_rx_frame_if;
    logic       phy_rx_dv;
    logic       phy_rx_er;
    logic [7:0] phy_rxd;
    logic       wr_full;
    logic       wr_en;
    logic [8:0] wr_data;

    modport master (
        input  phy_rx_dv, phy_rx_er, phy_rxd, wr_full,
        output wr_en, wr_data
    );

    modport slave (
        output phy_rx_dv, phy_rx_er, phy_rxd, wr_full,
        input  wr_en, wr_data
    );
endinterface

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks and removes the FCS, and emits
// 9-bit words {1,byte} per frame byte followed by one {0,status} word.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | between frames; a pending status word may be flushed here
// S_PREAMBLE | 0x55 bytes seen, waiting for the 0xD5 SFD
// S_DATA     | frame body: CRC, count, 4-byte FCS delay line, byte writes
// S_DROP     | unusable frame, wait for dv to fall
module gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic            phy_rx_clk,
    input  logic            sys_rst_n,
    gmii_rx_frame_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [12:0] MIN_L   = 13'(MIN_LEN);
    localparam logic [12:0] MAX_L   = 13'(MAX_LEN);
    // A byte leaves the delay line four bytes after it entered, so the write
    // window for byte index < MAX_LEN closes at entry count MAX_LEN + 4.
    localparam logic [12:0] WR_LIM  = 13'(MAX_LEN + 4);
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 32'hEDB8_8320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    logic        dv_q, er_q, full_q;
    logic [7:0]  rxd_q;

    state_t      state, state_d;
    logic [31:0] crc, crc_d;
    logic [12:0] cnt, cnt_d, cnt_inc;
    logic [31:0] dly, dly_d;
    logic [2:0]  dly_cnt, dly_cnt_d;
    logic        err_flag, err_d;
    logic        long_flag, long_d;
    logic        ovf_flag, ovf_d;
    logic        pend, pend_d;
    logic [7:0]  pend_status, pend_status_d;
    logic [7:0]  status;
    logic        wr_en_q, wr_en_d;
    logic [8:0]  wr_data_q, wr_data_d;

    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
            full_q <= 1'b0;
            rxd_q  <= 8'h00;
        end else begin
            dv_q   <= bus.phy_rx_dv;
            er_q   <= bus.phy_rx_er;
            full_q <= bus.wr_full;
            rxd_q  <= bus.phy_rxd;
        end
    end

    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d       = state;
        crc_d         = crc;
        cnt_d         = cnt;
        dly_d         = dly;
        dly_cnt_d     = dly_cnt;
        err_d         = err_flag;
        long_d        = long_flag;
        ovf_d         = ovf_flag;
        pend_d        = pend;
        pend_status_d = pend_status;
        wr_en_d       = 1'b0;
        wr_data_d     = 9'h000;
        cnt_inc       = (cnt == 13'h1FFF) ? cnt : cnt + 13'd1;
        status        = {3'b000, ovf_flag, long_flag, (cnt < MIN_L), err_flag, (crc == RESIDUE)};

        // Only S_IDLE/S_DROP can be active while pending, so this never
        // competes with a frame write.
        if (pend && !full_q) begin
            wr_en_d   = 1'b1;
            wr_data_d = {1'b0, pend_status};
            pend_d    = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (dv_q)
                    state_d = (rxd_q == 8'h55 && !pend) ? S_PREAMBLE : S_DROP;
            end

            S_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                end else if (rxd_q == 8'hD5) begin
                    state_d   = S_DATA;
                    crc_d     = 32'hFFFF_FFFF;
                    cnt_d     = 13'd0;
                    dly_d     = 32'h0000_0000;
                    dly_cnt_d = 3'd0;
                    err_d     = 1'b0;
                    long_d    = 1'b0;
                    ovf_d     = 1'b0;
                end else if (rxd_q != 8'h55) begin
                    state_d = S_DROP;
                end
            end

            S_DATA: begin
                if (dv_q) begin
                    crc_d = crc_byte(crc, rxd_q);
                    cnt_d = cnt_inc;
                    dly_d = {rxd_q, dly[31:8]};
                    if (er_q)
                        err_d = 1'b1;
                    if (cnt_inc > MAX_L)
                        long_d = 1'b1;
                    if (dly_cnt == 3'd4) begin
                        if (cnt_inc <= WR_LIM && !ovf_flag) begin
                            if (full_q) begin
                                ovf_d = 1'b1;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_data_d = {1'b1, dly[7:0]};
                            end
                        end
                    end else begin
                        dly_cnt_d = dly_cnt + 3'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (full_q) begin
                        pend_d        = 1'b1;
                        pend_status_d = status;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {1'b0, status};
                    end
                end
            end

            S_DROP: begin
                if (!dv_q)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc         <= 32'h0000_0000;
            cnt         <= 13'd0;
            dly         <= 32'h0000_0000;
            dly_cnt     <= 3'd0;
            err_flag    <= 1'b0;
            long_flag   <= 1'b0;
            ovf_flag    <= 1'b0;
            pend        <= 1'b0;
            pend_status <= 8'h00;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 9'h000;
        end else begin
            crc         <= crc_d;
            cnt         <= cnt_d;
            dly         <= dly_d;
            dly_cnt     <= dly_cnt_d;
            err_flag    <= err_d;
            long_flag   <= long_d;
            ovf_flag    <= ovf_d;
            pend        <= pend_d;
            pend_status <= pend_status_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Directed and randomized frames against a frame-level reference model of the receive framer.
module tb_gmii_rx_frame;
    typedef logic [7:0] byteq_t[$];

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gmii_rx_frame_if bus();

    gmii_rx_frame #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .phy_rx_clk (clk),
        .sys_rst_n  (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];

    always @(negedge clk)
        if (bus.wr_en) got.push_back(bus.wr_data);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Standard Ethernet FCS of the first n bytes.
    function automatic logic [31:0] fcs_of(input byteq_t d, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ d[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    function automatic byteq_t make_frame(input int npay, input bit rnd);
        byteq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < npay; i++)
            f.push_back(rnd ? 8'($urandom) : 8'(i));
        fcs = fcs_of(f, npay);
        for (int i = 0; i < 4; i++)
            f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    // Expected FIFO words for one frame; wr_full held over bytes [fs, fs+fl).
    function automatic void model(input byteq_t f, input bit er_seen, input int fs, input int fl);
        int len, nw, j;
        bit crc_ok, ovf;
        logic [31:0] tail;
        logic [7:0] st;
        len = f.size();
        nw  = (len > 4) ? len - 4 : 0;
        if (nw > MAX_LEN) nw = MAX_LEN;
        ovf = 1'b0;
        if (fl > 0) begin
            j = (fs > 4) ? fs : 4;
            if (j < fs + fl && j - 4 < nw) begin
                nw  = j - 4;
                ovf = 1'b1;
            end
        end
        crc_ok = 1'b0;
        if (len >= 4) begin
            tail   = {f[len-1], f[len-2], f[len-3], f[len-4]};
            crc_ok = (tail == fcs_of(f, len - 4));
        end
        st = {3'b000, ovf, (len > MAX_LEN), (len < MIN_LEN), er_seen, crc_ok};
        for (int i = 0; i < nw; i++)
            exp_q.push_back({1'b1, f[i]});
        exp_q.push_back({1'b0, st});
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.phy_rx_dv = 1'b0;
            bus.phy_rx_er = 1'b0;
            bus.phy_rxd   = 8'h00;
        end
    endtask

    task automatic send_frame(input byteq_t f, input int npre, input int er_idx,
                              input int fs, input int fl, input logic full_pre, input logic full_tail);
        for (int i = 0; i <= npre; i++) begin
            @(negedge clk);
            bus.phy_rx_dv = 1'b1;
            bus.phy_rx_er = 1'b0;
            bus.phy_rxd   = (i == npre) ? 8'hD5 : 8'h55;
            bus.wr_full   = full_pre;
        end
        for (int i = 0; i < f.size(); i++) begin
            @(negedge clk);
            bus.phy_rxd   = f[i];
            bus.phy_rx_er = (i == er_idx);
            bus.wr_full   = (i >= fs && i < fs + fl) ? 1'b1 : full_pre;
        end
        @(negedge clk);
        bus.phy_rx_dv = 1'b0;
        bus.phy_rx_er = 1'b0;
        bus.phy_rxd   = 8'h00;
        bus.wr_full   = full_tail;
    endtask

    task automatic compare(input string tag);
        check({tag, " word count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s word %0d", tag, i), got[i], exp_q[i]);
            if (got[i] !== exp_q[i]) break;
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        byteq_t f, fa, fb;
        int npay, npre, er_idx, flip;

        bus.phy_rx_dv = 1'b0;
        bus.phy_rx_er = 1'b0;
        bus.phy_rxd   = 8'h00;
        bus.wr_full   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset wr_en", bus.wr_en, 1'b0);
        check("reset wr_data", bus.wr_data, 9'h000);
        rst_n = 1'b1;
        idle(2);

        f = make_frame(60, 1'b0);
        send_frame(f, 7, -1, 0, 0, 1'b0, 1'b0);
        model(f, 1'b0, 0, 0);
        idle(6);
        compare("good64");

        f[63] = f[63] ^ 8'h01;
        send_frame(f, 7, -1, 0, 0, 1'b0, 1'b0);
        model(f, 1'b0, 0, 0);
        idle(6);
        compare("bad_fcs");

        f = make_frame(16, 1'b1);
        send_frame(f, 7, 5, 0, 0, 1'b0, 1'b0);
        model(f, 1'b1, 0, 0);
        idle(6);
        compare("runt_er");

        f = make_frame(1596, 1'b1);
        send_frame(f, 7, -1, 0, 0, 1'b0, 1'b0);
        model(f, 1'b0, 0, 0);
        idle(6);
        compare("oversize");

        f = make_frame(60, 1'b0);
        send_frame(f, 7, -1, 30, 3, 1'b0, 1'b0);
        model(f, 1'b0, 30, 3);
        idle(6);
        compare("overflow");

        f = make_frame(0, 1'b0);
        send_frame(f, 3, -1, 0, 0, 1'b0, 1'b0);
        model(f, 1'b0, 0, 0);
        idle(6);
        compare("tiny4");

        // Bad preamble byte, then a preamble cut short by dv falling.
        f = make_frame(20, 1'b1);
        @(negedge clk); bus.phy_rx_dv = 1'b1; bus.phy_rxd = 8'h55;
        @(negedge clk); bus.phy_rxd = 8'h55;
        @(negedge clk); bus.phy_rxd = 8'hAA;
        for (int i = 0; i < f.size(); i++) begin
            @(negedge clk); bus.phy_rxd = f[i];
        end
        idle(1);
        @(negedge clk); bus.phy_rx_dv = 1'b1; bus.phy_rxd = 8'h55;
        @(negedge clk); bus.phy_rxd = 8'h55;
        idle(6);
        compare("bad_preamble");

        fa = make_frame(60, 1'b1);
        fb = make_frame(70, 1'b1);
        send_frame(fa, 7, -1, 0, 0, 1'b0, 1'b0);
        send_frame(fb, 1, -1, 0, 0, 1'b0, 1'b0);
        model(fa, 1'b0, 0, 0);
        model(fb, 1'b0, 0, 0);
        idle(6);
        compare("back_to_back");

        // Status held while full; a frame arriving meanwhile is silently dropped.
        fa = make_frame(60, 1'b0);
        fb = make_frame(60, 1'b1);
        send_frame(fa, 7, -1, 0, 0, 1'b0, 1'b1);
        send_frame(fb, 7, -1, 0, 0, 1'b1, 1'b1);
        idle(3);
        check("pending held", got.size(), 60);
        bus.wr_full = 1'b0;
        idle(6);
        model(fa, 1'b0, 0, 0);
        compare("pending");

        for (int n = 0; n < 10; n++) begin
            npay   = $urandom_range(120, 1);
            npre   = $urandom_range(8, 1);
            f      = make_frame(npay, 1'b1);
            er_idx = ($urandom_range(3, 0) == 0) ? $urandom_range(f.size() - 1, 0) : -1;
            if ($urandom_range(2, 0) == 0) begin
                flip = $urandom_range(f.size() - 1, 0);
                f[flip] = f[flip] ^ 8'(1 << $urandom_range(7, 0));
            end
            send_frame(f, npre, er_idx, 0, 0, 1'b0, 1'b0);
            model(f, (er_idx >= 0), 0, 0);
            idle($urandom_range(4, 1));
            idle(6);
            compare($sformatf("random%0d", n));
        end

        // Reset in the middle of a frame while bytes are being written.
        f = make_frame(60, 1'b0);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            bus.phy_rx_dv = 1'b1;
            bus.phy_rxd   = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); bus.phy_rxd = f[i];
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midframe reset wr_en", bus.wr_en, 1'b0);
        check("midframe reset wr_data", bus.wr_data, 9'h000);
        got.delete();
        for (int i = 25; i < f.size(); i++) begin
            @(negedge clk); bus.phy_rxd = f[i];
            if (i == 27) rst_n = 1'b1;
        end
        idle(8);
        compare("midframe_reset");

        f = make_frame(60, 1'b1);
        send_frame(f, 7, -1, 0, 0, 1'b0, 1'b0);
        model(f, 1'b0, 0, 0);
        idle(6);
        compare("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
